// File: rtl/rename_pkg.sv
// Shared types for the rename-stage free-list controller:
// architectural constants, controller states and the in-flight entry.
package rename_pkg;

  localparam int ARCH_REGS = 32;
  localparam int ARCH_W    = 5;
  localparam int PRF_W     = 7;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    WALK
  } state_t;

  // One uncommitted allocation at the default physical width.
  typedef struct packed {
    logic [ARCH_W-1:0] rd;
    logic [PRF_W-1:0]  prd;
    logic [PRF_W-1:0]  old_prd;
  } inflight_ent_t;

endpackage

// File: rtl/rename_inflight_buf.sv
// Circular in-flight buffer: push/pop-youngest at the tail, pop-oldest
// at the head. Ports: clock, reset_n, push, head_pop, tail_pop, data, count.
module rename_inflight_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 19
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     head_pop,
  input  logic                     tail_pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [WIDTH-1:0]         tail_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;

  // tail points at the next free slot; the youngest entry sits just below.
  assign head_data = mem[head];
  assign tail_data = mem[tail - AW'(1)];

  always_ff @(posedge clock) begin
    if (push) begin
      mem[tail] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(head_pop);
      tail  <= tail + AW'(push) - AW'(tail_pop);
      count <= count + CW'(push)
             - CW'(head_pop) - CW'(tail_pop);
    end
  end

endmodule

// File: rtl/reg_rename_ctrl.sv
// Rename controller: owns the RAT, allocates from the free list, frees on
// commit and walks back uncommitted allocations on flush. Ports: ren_*, cmt_*, fl_*.
module reg_rename_ctrl
  import rename_pkg::*;
#(
  parameter int REG_FILE_ADDR_WIDTH = PRF_W,
  parameter int INFLIGHT_DEPTH      = 16
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  ren_valid,
  output logic                                  ren_ready,
  input  logic [4:0]                            ren_rd,
  input  logic [4:0]                            ren_rs1,
  input  logic [4:0]                            ren_rs2,
  input  logic                                  ren_has_rd,
  output logic [REG_FILE_ADDR_WIDTH-1:0]        ren_prs1,
  output logic [REG_FILE_ADDR_WIDTH-1:0]        ren_prs2,
  output logic [REG_FILE_ADDR_WIDTH-1:0]        ren_prd,
  output logic [REG_FILE_ADDR_WIDTH-1:0]        ren_old_prd,
  input  logic                                  cmt_valid,
  output logic                                  cmt_ready,
  input  logic                                  flush,
  output logic                                  busy,
  output logic [$clog2(INFLIGHT_DEPTH):0]       inflight_count,
  output logic                                  fl_take,
  input  logic [REG_FILE_ADDR_WIDTH-1:0]        fl_free_reg,
  input  logic                                  fl_empty,
  output logic                                  fl_freed,
  output logic [REG_FILE_ADDR_WIDTH-1:0]        fl_freed_reg
);

  localparam int W  = REG_FILE_ADDR_WIDTH;
  localparam int D  = INFLIGHT_DEPTH;
  localparam int CW = $clog2(D) + 1;
  localparam int EW = ARCH_W + 2 * W;

  typedef struct packed {
    logic [ARCH_W-1:0] rd;
    logic [W-1:0]      prd;
    logic [W-1:0]      old_prd;
  } ent_t;

  state_t         state;
  logic [W-1:0]   rat [ARCH_REGS];
  ent_t           push_ent;
  ent_t           head_ent;
  ent_t           tail_ent;
  logic [CW-1:0]  count;
  logic           run;
  logic           walk;
  logic           alloc;
  logic           ren_fire;
  logic           cmt_fire;
  logic           push;

  // Gating on reset_n keeps every output quiet while reset is held.
  assign run   = reset_n && (state == RUN);
  assign walk  = reset_n && (state == WALK);
  assign alloc = ren_has_rd && (ren_rd != '0);

  assign ren_ready = run && !flush
                  && (!alloc || (!fl_empty && count < CW'(D)));
  assign ren_fire  = ren_valid && ren_ready;
  assign push      = ren_fire && alloc;

  assign cmt_ready = run && (count != '0);
  assign cmt_fire  = cmt_valid && cmt_ready;

  assign ren_prs1 = (run && ren_rs1 != '0) ? rat[ren_rs1] : '0;
  assign ren_prs2 = (run && ren_rs2 != '0) ? rat[ren_rs2] : '0;
  assign ren_old_prd = run ? rat[ren_rd] : '0;
  assign ren_prd  = (run && alloc) ? fl_free_reg : '0;
  assign fl_take  = push;

  assign busy           = !reset_n || (state != RUN);
  assign inflight_count = reset_n ? count : '0;

  // Commit (RUN) and walk (WALK) are exclusive by state.
  assign fl_freed = cmt_fire || walk;

  always_comb begin
    fl_freed_reg = '0;
    unique case (1'b1)
      cmt_fire: fl_freed_reg = head_ent.old_prd;
      walk:     fl_freed_reg = tail_ent.prd;
      default:  fl_freed_reg = '0;
    endcase
  end

  assign push_ent = '{
    rd:      ren_rd,
    prd:     fl_free_reg,
    old_prd: rat[ren_rd]
  };

  rename_inflight_buf #(
    .DEPTH (D),
    .WIDTH (EW)
  ) u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_ent),
    .head_pop  (cmt_fire),
    .tail_pop  (walk),
    .head_data (head_ent),
    .tail_data (tail_ent),
    .count     (count)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= INIT;
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat[i] <= W'(i);
      end
    end else begin
      unique case (state)
        INIT: state <= RUN;
        RUN: begin
          if (push) begin
            rat[ren_rd] <= fl_free_reg;
          end
          // A same-cycle commit retires before the walk is sized.
          if (flush && (count - CW'(cmt_fire)) != '0) begin
            state <= WALK;
          end
        end
        WALK: begin
          rat[tail_ent.rd] <= tail_ent.old_prd;
          if (count == CW'(1)) begin
            state <= RUN;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_rename_ctrl.sv
// Bench for reg_rename_ctrl: queue-based reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_reg_rename_ctrl;

  logic       clock;
  logic       reset_n;
  logic       ren_valid;
  logic       ren_ready;
  logic [4:0] ren_rd;
  logic [4:0] ren_rs1;
  logic [4:0] ren_rs2;
  logic       ren_has_rd;
  logic [6:0] ren_prs1;
  logic [6:0] ren_prs2;
  logic [6:0] ren_prd;
  logic [6:0] ren_old_prd;
  logic       cmt_valid;
  logic       cmt_ready;
  logic       flush;
  logic       busy;
  logic [4:0] inflight_count;
  logic       fl_take;
  logic [6:0] fl_free_reg;
  logic       fl_empty;
  logic       fl_freed;
  logic [6:0] fl_freed_reg;

  reg_rename_ctrl #(
    .REG_FILE_ADDR_WIDTH (7),
    .INFLIGHT_DEPTH      (16)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ren_valid      (ren_valid),
    .ren_ready      (ren_ready),
    .ren_rd         (ren_rd),
    .ren_rs1        (ren_rs1),
    .ren_rs2        (ren_rs2),
    .ren_has_rd     (ren_has_rd),
    .ren_prs1       (ren_prs1),
    .ren_prs2       (ren_prs2),
    .ren_prd        (ren_prd),
    .ren_old_prd    (ren_old_prd),
    .cmt_valid      (cmt_valid),
    .cmt_ready      (cmt_ready),
    .flush          (flush),
    .busy           (busy),
    .inflight_count (inflight_count),
    .fl_take        (fl_take),
    .fl_free_reg    (fl_free_reg),
    .fl_empty       (fl_empty),
    .fl_freed       (fl_freed),
    .fl_freed_reg   (fl_freed_reg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference model: architectural map, list of uncommitted
  // allocations oldest-first, plus "just left reset" and "unwinding".
  typedef struct {
    int rd;
    int prd;
    int old;
  } ment_t;

  ment_t q[$];
  int    mrat[32];
  bit    init_pend = 1'b1;
  bit    walking = 1'b0;
  ment_t me;
  bit    m_alloc;
  bit    m_rr;

  initial begin
    for (int i = 0; i < 32; i++) mrat[i] = i;
  end

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mrat[i] = i;
      q.delete();
      init_pend = 1'b1;
      walking = 1'b0;
    end else if (init_pend) begin
      init_pend = 1'b0;
    end else if (walking) begin
      me = q.pop_back();
      mrat[me.rd] = me.old;
      if (q.size() == 0) walking = 1'b0;
    end else begin
      m_alloc = ren_has_rd && ren_rd != 0;
      m_rr = !flush && (!m_alloc || (!fl_empty && q.size() < 16));
      if (cmt_valid && q.size() > 0) void'(q.pop_front());
      if (ren_valid && m_rr && m_alloc) begin
        q.push_back('{int'(ren_rd), int'(fl_free_reg),
                      mrat[ren_rd]});
        mrat[ren_rd] = int'(fl_free_reg);
      end
      if (flush && q.size() > 0) walking = 1'b1;
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  bit e_busy, e_rr, e_cr, e_take, e_freed, e_chk_reg, e_ren;
  int e_freg, e_cnt, e_alloc;

  always @(negedge clock) begin
    e_busy = 1'b1; e_rr = 0; e_cr = 0; e_take = 0;
    e_freed = 0; e_chk_reg = 0; e_ren = 0; e_freg = 0;
    e_cnt = q.size();
    e_alloc = (ren_has_rd && ren_rd != 0) ? 1 : 0;
    if (!reset_n) begin
      e_cnt = 0;
      e_chk_reg = 1;
    end else if (init_pend) begin
      e_busy = 1;
    end else if (walking) begin
      e_freed = 1;
      e_chk_reg = 1;
      e_freg = q[$].prd;
    end else begin
      e_busy = 0;
      e_rr = !flush && (e_alloc == 0 || (!fl_empty && q.size() < 16));
      e_cr = q.size() > 0;
      e_take = ren_valid && e_rr && e_alloc != 0;
      e_freed = cmt_valid && e_cr;
      if (e_freed) begin
        e_chk_reg = 1;
        e_freg = q[0].old;
      end
      e_ren = ren_valid && e_rr;
    end
    chk("m_busy", busy, e_busy);
    chk("m_ren_ready", ren_ready, e_rr);
    chk("m_cmt_ready", cmt_ready, e_cr);
    chk("m_fl_take", fl_take, e_take);
    chk("m_fl_freed", fl_freed, e_freed);
    chk("m_count", inflight_count, e_cnt);
    if (e_chk_reg) chk("m_freed_reg", fl_freed_reg, e_freg);
    if (e_ren) begin
      chk("m_prs1", ren_prs1, ren_rs1 == 0 ? 0 : mrat[ren_rs1]);
      chk("m_prs2", ren_prs2, ren_rs2 == 0 ? 0 : mrat[ren_rs2]);
      chk("m_old_prd", ren_old_prd, mrat[ren_rd]);
      chk("m_prd", ren_prd, e_alloc != 0 ? int'(fl_free_reg) : 0);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic ren(input bit v, input bit has, input int rd,
                     input int rs1, input int rs2, input int fr);
    ren_valid   = v;
    ren_has_rd  = has;
    ren_rd      = 5'(rd);
    ren_rs1     = 5'(rs1);
    ren_rs2     = 5'(rs2);
    fl_free_reg = 7'(fr);
  endtask

  initial begin
    reset_n = 0; cmt_valid = 0; flush = 0; fl_empty = 0;
    ren(0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    #2;
    chk("rst_busy", busy, 1);
    chk("rst_freed", fl_freed, 0);
    chk("rst_ren_ready", ren_ready, 0);
    chk("rst_count", inflight_count, 0);
    cyc();
    reset_n = 1;
    #2;
    chk("init_busy", busy, 1);
    chk("init_ren_ready", ren_ready, 0);
    cyc();

    // First allocation, then lookup of the new mapping.
    ren(1, 1, 5, 0, 0, 32);
    #2;
    chk("t1_prd", ren_prd, 32);
    chk("t1_old_prd", ren_old_prd, 5);
    chk("t1_take", fl_take, 1);
    cyc();
    ren(1, 0, 0, 5, 6, 0);
    #2;
    chk("t1_prs1", ren_prs1, 32);
    chk("t1_prs2", ren_prs2, 6);
    chk("t1_take_off", fl_take, 0);
    cyc();

    // Non-allocating renames, even with an empty free list.
    fl_empty = 1;
    ren(1, 1, 0, 0, 0, 99);
    #2;
    chk("t2_ready_x0", ren_ready, 1);
    chk("t2_take_x0", fl_take, 0);
    chk("t2_prd_x0", ren_prd, 0);
    cyc();
    ren(1, 0, 7, 0, 0, 99);
    #2;
    chk("t2_ready_nord", ren_ready, 1);
    cyc();
    fl_empty = 0;
    ren(0, 0, 0, 0, 0, 0);
    #2;
    chk("t2_count", inflight_count, 1);

    // Commit returns the superseded register.
    cmt_valid = 1;
    #1;
    chk("t3_freed", fl_freed, 1);
    chk("t3_freed_reg", fl_freed_reg, 5);
    cyc();
    #2;
    chk("t3_count", inflight_count, 0);
    chk("t3_cmt_ready", cmt_ready, 0);
    cmt_valid = 0;
    cyc();

    // Flush walk, youngest first; flush held into the walk is ignored.
    ren(1, 1, 1, 0, 0, 32); cyc();
    ren(1, 1, 1, 0, 0, 33); cyc();
    ren(1, 1, 2, 0, 0, 34); cyc();
    ren(0, 0, 0, 0, 0, 0);
    flush = 1;
    #2;
    chk("t4_ready_flush", ren_ready, 0);
    cyc();
    #2;
    chk("t4_busy1", busy, 1);
    chk("t4_walk1", fl_freed_reg, 34);
    cyc();
    flush = 0;
    #2;
    chk("t4_walk2", fl_freed_reg, 33);
    cyc();
    #2;
    chk("t4_walk3", fl_freed_reg, 32);
    cyc();
    ren(1, 0, 0, 1, 2, 0);
    #2;
    chk("t4_busy_end", busy, 0);
    chk("t4_prs1", ren_prs1, 1);
    chk("t4_prs2", ren_prs2, 2);
    cyc();

    // Full buffer, then empty free list.
    for (int i = 0; i < 16; i++) begin
      ren(1, 1, i + 1, 0, 0, 40 + i);
      cyc();
    end
    ren(1, 1, 20, 0, 0, 70);
    #2;
    chk("t5_full_alloc", ren_ready, 0);
    chk("t5_full_count", inflight_count, 16);
    ren_has_rd = 0;
    #1;
    chk("t5_full_noalloc", ren_ready, 1);
    ren(0, 0, 0, 0, 0, 0);
    cmt_valid = 1;
    repeat (16) cyc();
    cmt_valid = 0;
    #2;
    chk("t5_drained", inflight_count, 0);
    fl_empty = 1;
    ren(0, 1, 9, 0, 0, 0);
    #1;
    chk("t5_empty_fl", ren_ready, 0);
    fl_empty = 0;
    #1;
    chk("t5_fl_ok", ren_ready, 1);
    cyc();

    // Flush with a same-cycle commit: commit first, one walk cycle.
    ren(1, 1, 3, 0, 0, 50); cyc();
    ren(1, 1, 4, 0, 0, 51); cyc();
    ren(0, 0, 0, 0, 0, 0);
    flush = 1;
    cmt_valid = 1;
    #2;
    chk("t6_cmt_freed", fl_freed, 1);
    chk("t6_cmt_reg", fl_freed_reg, 42);
    cyc();
    flush = 0;
    #2;
    chk("t6_walk_reg", fl_freed_reg, 51);
    chk("t6_walk_cmt_rdy", cmt_ready, 0);
    cyc();
    cmt_valid = 0;
    ren(1, 0, 0, 4, 3, 0);
    #2;
    chk("t6_busy", busy, 0);
    chk("t6_prs_x4", ren_prs1, 43);
    chk("t6_prs_x3", ren_prs2, 50);
    cyc();

    // Reset in the middle of a walk.
    ren(1, 1, 6, 0, 0, 60); cyc();
    ren(1, 1, 7, 0, 0, 61); cyc();
    ren(1, 1, 8, 0, 0, 62); cyc();
    ren(0, 0, 0, 0, 0, 0);
    flush = 1;
    cyc();
    flush = 0;
    #2;
    chk("t7_walk1", fl_freed_reg, 62);
    cyc();
    reset_n = 0;
    cyc();
    reset_n = 1;
    #2;
    chk("t7_init_busy", busy, 1);
    chk("t7_init_freed", fl_freed, 0);
    chk("t7_init_count", inflight_count, 0);
    cyc();
    ren(1, 0, 0, 6, 7, 0);
    #2;
    chk("t7_run", busy, 0);
    chk("t7_prs_x6", ren_prs1, 6);
    chk("t7_prs_x7", ren_prs2, 7);
    cyc();
    ren(1, 0, 0, 3, 4, 0);
    #2;
    chk("t7_prs_x3", ren_prs1, 3);
    chk("t7_prs_x4", ren_prs2, 4);
    cyc();
    ren(0, 0, 0, 0, 0, 0);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
